seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter WIDTH, default 14: binary input width, legal range 1..27.
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_valid, input, 1 bit: i_value is offered for display.
REQ-007 SHALL have port i_value, input, WIDTH bits: unsigned binary value.
REQ-008 SHALL have port o_ready, output, 1 bit: the block accepts a new value.
REQ-009 SHALL have port o_seg7, output, 7 bits: active-low segments, bit6=g through bit0=a.
REQ-010 SHALL have port o_an, output, DIGITS bits: active-low digit enables; bit 0 is the least-significant digit.
REQ-011 SHALL have port o_ovf, output, 1 bit: the displayed value exceeded the digit capacity.

Function
REQ-012 SHALL capture i_value on a clock edge where i_valid and o_ready are both 1 (the handshake), then go from IDLE to CONV.
REQ-013 SHALL use three states: IDLE (o_ready=1), CONV (o_ready=0), COMMIT (o_ready=0).
REQ-014 SHALL, in CONV, run sequential shift-add-3 binary-to-BCD conversion, one input bit per cycle MSB first, into a 4*DIGITS-bit register for exactly WIDTH cycles, then go to COMMIT.
REQ-015 SHALL, in COMMIT, load the BCD result and the overflow flag into the display registers in one cycle, then return to IDLE; o_ready is therefore 1 again WIDTH+2 cycles after the handshake edge.
REQ-016 SHALL compare the captured value against 10^DIGITS at capture; if value >= 10^DIGITS, o_ovf SHALL be 1 from COMMIT onward and every digit SHALL display dash 7'b011_1111.
REQ-017 SHALL hold o_ovf until the next COMMIT.
REQ-018 SHALL ignore i_valid while o_ready=0: no capture, and the conversion in progress is undisturbed.
REQ-019 SHALL run a free-running prescaler 0..SCAN_DIV-1; its terminal count is a tick.
REQ-020 SHALL, on each tick, register o_an (only bit idx low) and o_seg7 (glyph of digit idx), then advance idx, wrapping from DIGITS-1 to 0.
REQ-021 SHALL use glyphs 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000; any BCD nibble >9 SHALL display all-off 1111111.
REQ-022 SHALL let the scan continue uninterrupted during conversion; a COMMIT becomes visible on the next tick for each digit.
REQ-023 SHALL treat DIGITS=1 as idx constant 0, with o_an=0 after the first tick.

Reset
REQ-024 SHALL, while i_rst_n=0, asynchronously force: state IDLE, o_ready=1, o_seg7=1111111, o_an all ones, o_ovf=0, display BCD=0, idx=0, prescaler=0.
REQ-025 SHALL, on reset assertion mid-conversion, abort the conversion; the value SHALL never be committed.
REQ-026 SHALL show the first digit (digit 0, glyph 0) at the tick SCAN_DIV cycles after reset release.

Configuration
REQ-027 SHALL, with macro SEG7_LEADING_ZERO_BLANK_EN defined, blank (1111111) every zero digit above the most-significant nonzero digit; digit 0 is never blanked; no blanking applies when o_ovf=1.
REQ-028 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all digits including leading zeros.

Verification (DIGITS=4, WIDTH=14, SCAN_DIV=4)
REQ-029 SHALL test: reset, then idle 20 cycles -> o_an cycles 1110,1101,1011,0111 every 4 cycles; o_seg7=1000000 each slot; o_seg7=1111111 and o_an=1111 before the first tick.
REQ-030 SHALL test: handshake with i_value=1234 -> o_ready low 16 cycles; next full scan shows digits 4,3,2,1 (0011001, 0110000, 0100100, 1111001).
REQ-031 SHALL test: i_value=10000 -> o_ovf=1; all four slots show 0111111.
REQ-032 SHALL test: i_valid with 42 during a conversion of 9999 -> 42 ignored; display 9999; o_ready returns after 16 cycles.
REQ-033 SHALL test: reset pulsed during a conversion of 567 -> display stays 0000; o_ready=1 immediately.
REQ-034 SHALL test: with SEG7_LEADING_ZERO_BLANK_EN, value 7 -> digits 3..1 show 1111111 and digit 0 shows 1011000; value 0 -> only digit 0 shows 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: serial shift-add-3 binary-to-BCD conversion feeding a scanned display.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant nonzero digit.

module seg7_digit_glyph (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b111_1111;
    if (dash) seg = 7'b011_1111;
    else if (!blank) begin
      case (nib)
        4'd0:    seg = 7'b100_0000;
        4'd1:    seg = 7'b111_1001;
        4'd2:    seg = 7'b010_0100;
        4'd3:    seg = 7'b011_0000;
        4'd4:    seg = 7'b001_1001;
        4'd5:    seg = 7'b001_0010;
        4'd6:    seg = 7'b000_0010;
        4'd7:    seg = 7'b101_1000;
        4'd8:    seg = 7'b000_0000;
        4'd9:    seg = 7'b001_0000;
        default: seg = 7'b111_1111;
      endcase
    end
  end
endmodule

module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_value,
  output logic              o_ready,
  output logic [6:0]        o_seg7,
  output logic [DIGITS-1:0] o_an,
  output logic              o_ovf
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] CAPACITY = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       shreg;
  logic [DIGITS-1:0][3:0] bcd, bcd_adj, disp_bcd;
  logic [4*DIGITS-1:0]    adj_flat;
  logic [CW-1:0]          cnt;
  logic                   ovf_cap;
  logic                   hs;
  logic                   conv_done;

  assign hs        = (state == IDLE) && i_valid;
  assign conv_done = (cnt == CW'(WIDTH));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = CONV;
      end
      CONV:    if (conv_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      if (bcd[k] >= 4'd5) bcd_adj[k] = bcd[k] + 4'd3;
  end
  assign adj_flat = bcd_adj;

  // WIDTH shift cycles, then one settle cycle with cnt==WIDTH before COMMIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_cap  <= 1'b0;
      disp_bcd <= '0;
      o_ovf    <= 1'b0;
    end else begin
      if (hs) begin
        shreg   <= i_value;
        bcd     <= '0;
        cnt     <= '0;
        ovf_cap <= (64'(i_value) >= CAPACITY);
      end else if (state == CONV && !conv_done) begin
        shreg <= shreg << 1;
        bcd   <= {adj_flat[4*DIGITS-2:0], shreg[WIDTH-1]};
        cnt   <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        disp_bcd <= bcd;
        o_ovf    <= ovf_cap;
      end
    end
  end

  logic [DIGITS-1:0][6:0] glyph;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run          = run && (disp_bcd[k] == 4'd0);
      lead_zero[k] = run;
    end
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank = (g != 0) && lead_zero[g] && !o_ovf;
`else
    assign blank = 1'b0;
`endif
    seg7_digit_glyph u_glyph (
      .nib   (disp_bcd[g]),
      .blank (blank),
      .dash  (o_ovf),
      .seg   (glyph[g])
    );
  end

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          tick;

  assign tick = (pre == PW'(SCAN_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre    <= '0;
      idx    <= '0;
      o_an   <= '1;
      o_seg7 <= 7'b111_1111;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        o_an   <= ~(DIGITS'(1) << idx);
        o_seg7 <= glyph[idx];
        idx    <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: arithmetic display model checked every cycle plus literal slot checks.
`timescale 1ns/1ps
module tb_seg7_scan_driver;
  localparam int DIGITS   = 4;
  localparam int WIDTH    = 14;
  localparam int SCAN_DIV = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [WIDTH-1:0]  i_value = '0;
  logic              o_ready;
  logic [6:0]        o_seg7;
  logic [DIGITS-1:0] o_an;
  logic              o_ovf;

  int cmp = 0;
  int mis = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_value (i_value),
    .o_ready (o_ready),
    .o_seg7  (o_seg7),
    .o_an    (o_an),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [6:0] dec_glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1011000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] model_glyph(input int v, input bit ovf, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ovf) return 7'b0111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 7'b1111111;
`endif
    return dec_glyph((v / p) % 10);
  endfunction

  // Model: edge count since reset drives the scan; a capture commits WIDTH+2 edges later.
  int                n_edges, rem, conv_val, disp_val;
  bit                busy, disp_ovf;
  logic [DIGITS-1:0] exp_an;
  logic [6:0]        exp_seg;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_edges = 0; busy = 0; rem = 0; disp_val = 0; disp_ovf = 0;
      exp_an = '1; exp_seg = 7'b1111111;
    end else begin
      n_edges++;
      if (n_edges % SCAN_DIV == 0) begin
        int slot;
        slot    = (n_edges / SCAN_DIV - 1) % DIGITS;
        exp_an  = ~(DIGITS'(1) << slot);
        exp_seg = model_glyph(disp_val, disp_ovf, slot);
      end
      if (busy) begin
        rem--;
        if (rem == 0) begin
          busy = 0;
          disp_val = conv_val;
          disp_ovf = (conv_val >= 10 ** DIGITS);
        end
      end else if (i_valid) begin
        busy = 1; rem = WIDTH + 2; conv_val = int'(i_value);
      end
    end
  end

  always @(negedge i_clk) begin
    cmp += 4;
    if (o_an !== exp_an) begin mis++; $display("FAIL cyc_an: got %b want %b", o_an, exp_an); end
    if (o_seg7 !== exp_seg) begin mis++; $display("FAIL cyc_seg7: got %b want %b", o_seg7, exp_seg); end
    if (o_ovf !== disp_ovf) begin mis++; $display("FAIL cyc_ovf: got %b want %b", o_ovf, disp_ovf); end
    if (o_ready !== !busy) begin mis++; $display("FAIL cyc_ready: got %b want %b", o_ready, !busy); end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Wait for a fresh tick into this slot, then check its glyph.
  task automatic check_slot(input int idx, input logic [6:0] exp, input string name);
    logic [DIGITS-1:0] tgt;
    int w;
    tgt = ~(DIGITS'(1) << idx);
    w = 0;
    while (o_an == tgt && w < 64) begin @(negedge i_clk); w++; end
    while (o_an != tgt && w < 64) begin @(negedge i_clk); w++; end
    if (w >= 64) begin
      cmp++; mis++;
      $display("FAIL %s: slot %0d not scanned within 64 cycles", name, idx);
    end else chk(name, 32'(o_seg7), 32'(exp));
  endtask

  // Handshake one value; returns the number of cycles o_ready stayed low.
  task automatic send(input int v, input bit inject, output int low);
    int w;
    w = 0;
    while (!o_ready && w < 100) begin @(negedge i_clk); w++; end
    i_valid = 1'b1;
    i_value = WIDTH'(v);
    @(negedge i_clk);
    i_valid = 1'b0;
    low = 0;
    while (!o_ready && low < 100) begin
      low++;
      if (inject) begin
        i_valid = (low >= 2 && low < 7);
        i_value = WIDTH'(42);
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
  endtask

  function automatic logic [6:0] zero_slot(input int idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0) return 7'b1111111;
`endif
    return 7'b1000000;
  endfunction

  initial begin
    int low;
    logic [6:0] g1234 [4];
    g1234[0] = 7'b0011001; g1234[1] = 7'b0110000;
    g1234[2] = 7'b0100100; g1234[3] = 7'b1111001;

    repeat (3) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("rst_an", 32'(o_an), 32'h0000000F);
    chk("rst_seg7", 32'(o_seg7), 32'h0000007F);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    repeat (2) @(negedge i_clk);
    chk("pre_tick_an", 32'(o_an), 32'h0000000F);
    for (int s = 0; s < DIGITS; s++) check_slot(s, zero_slot(s), "idle_zero");
    repeat (8) @(negedge i_clk);

    send(1234, 1'b0, low);
    chk("ready_low_1234", 32'(low), 32'd16);
    for (int s = 0; s < DIGITS; s++) check_slot(s, g1234[s], "disp_1234");
    chk("ovf_1234", 32'(o_ovf), 32'd0);

    send(10000, 1'b0, low);
    chk("ready_low_10000", 32'(low), 32'd16);
    chk("ovf_10000", 32'(o_ovf), 32'd1);
    for (int s = 0; s < DIGITS; s++) check_slot(s, 7'b0111111, "dash_10000");

    send(9999, 1'b1, low);
    chk("ready_low_9999", 32'(low), 32'd16);
    chk("ovf_9999", 32'(o_ovf), 32'd0);
    for (int s = 0; s < DIGITS; s++) check_slot(s, 7'b0010000, "disp_9999");

    // Reset mid-conversion of 567: display returns to zero, nothing commits
    while (!o_ready) @(negedge i_clk);
    i_valid = 1'b1; i_value = WIDTH'(567);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_an", 32'(o_an), 32'h0000000F);
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk);
    chk("abort_ready_idle", 32'(o_ready), 32'd1);
    for (int s = 0; s < DIGITS; s++) check_slot(s, zero_slot(s), "abort_disp");

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    send(7, 1'b0, low);
    check_slot(0, 7'b1011000, "blank7_d0");
    for (int s = 1; s < DIGITS; s++) check_slot(s, 7'b1111111, "blank7_hi");
    send(0, 1'b0, low);
    check_slot(0, 7'b1000000, "blank0_d0");
    for (int s = 1; s < DIGITS; s++) check_slot(s, 7'b1111111, "blank0_hi");
`endif

    repeat (4) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
